// File: rtl/ast_width_pkg.sv
// Shared constants and helpers for the Avalon-ST width extender/reducer pair.
// Word/beat sizes below describe the default 256 <-> 64 configuration.
package ast_width_pkg;

    localparam int unsigned DEF_DATA_IN_W  = 256;
    localparam int unsigned DEF_DATA_OUT_W = 64;
    localparam int unsigned DEF_CHANNEL_W  = 10;

    localparam int unsigned WORD_IN  = DEF_DATA_IN_W / 8;
    localparam int unsigned WORD_OUT = DEF_DATA_OUT_W / 8;
    localparam int unsigned RATIO    = WORD_IN / WORD_OUT;

    typedef enum logic {
        StEmpty,
        StSend
    } red_state_e;

    function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
        return (num + den - 1) / den;
    endfunction

    // Field width for a count of n items, never narrower than one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ast_width_reducer_if.sv
// Avalon-ST streaming bundle; master drives the stream, slave returns ready.
interface ast_width_reducer_if #(
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned EMPTY_W   = 3,
    parameter int unsigned CHANNEL_W = 10
) ();

    logic [DATA_W-1:0]    data;
    logic                 startofpacket;
    logic                 endofpacket;
    logic                 valid;
    logic [EMPTY_W-1:0]   empty;
    logic [CHANNEL_W-1:0] channel;
    logic                 ready;

    modport master (
        output data,
        output startofpacket,
        output endofpacket,
        output valid,
        output empty,
        output channel,
        input  ready
    );

    modport slave (
        input  data,
        input  startofpacket,
        input  endofpacket,
        input  valid,
        input  empty,
        input  channel,
        output ready
    );

endinterface

// File: rtl/ast_width_reducer.sv
// Avalon-ST width down-converter: each wide word is replayed as narrow beats, MSB byte first,
// keeping sop/eop/empty/channel; a new word is accepted in the same cycle the last beat leaves.
module ast_width_reducer
    import ast_width_pkg::*;
#(
    parameter int unsigned DATA_IN_W   = DEF_DATA_IN_W,
    parameter int unsigned DATA_OUT_W  = DEF_DATA_OUT_W,
    parameter int unsigned CHANNEL_W   = DEF_CHANNEL_W,
    parameter int unsigned EMPTY_IN_W  = clog2_min1(DATA_IN_W / 8),
    parameter int unsigned EMPTY_OUT_W = clog2_min1(DATA_OUT_W / 8)
) (
    input logic                 clk_i,
    input logic                 arstn_i,
    ast_width_reducer_if.slave  ast_in,
    ast_width_reducer_if.master ast_out
);

    localparam int unsigned BYTES_IN  = DATA_IN_W / 8;
    localparam int unsigned BYTES_OUT = DATA_OUT_W / 8;
    localparam int unsigned BEATS_MAX = BYTES_IN / BYTES_OUT;
    localparam int unsigned CNT_W     = clog2_min1(BEATS_MAX + 1);

    red_state_e             state_q, state_d;
    logic [DATA_IN_W-1:0]   buf_q, buf_d;
    logic                   sop_q, sop_d;
    logic                   eop_q, eop_d;
    logic [CHANNEL_W-1:0]   chan_q, chan_d;
    logic [EMPTY_OUT_W-1:0] empty_q, empty_d;
    logic [CNT_W-1:0]       total_q, total_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   rdy_en_q;

    logic        out_valid;
    logic        last_beat;
    logic        in_ready;
    logic        in_xfer;
    logic        out_xfer;
    int unsigned in_bytes;
    int unsigned in_beats;
    int unsigned in_pad;

    // Beat count and last-beat padding of the word currently offered at the input.
    always_comb begin
        in_bytes = BYTES_IN;
        if (ast_in.endofpacket) begin
            in_bytes = BYTES_IN - 32'(ast_in.empty);
        end
        in_beats = ceil_div(in_bytes, BYTES_OUT);
        in_pad   = in_beats * BYTES_OUT - in_bytes;
    end

    always_comb begin
        out_valid = (state_q == StSend);
        last_beat = (cnt_q == total_q - CNT_W'(1));
        out_xfer  = out_valid & ast_out.ready;
        // Zero-bubble: the buffer frees up in the same cycle its last beat is taken.
        in_ready  = rdy_en_q & (!out_valid | (out_xfer & last_beat));
        in_xfer   = ast_in.valid & in_ready;
    end

    always_comb begin
        ast_in.ready          = in_ready;
        ast_out.valid         = out_valid;
        ast_out.data          = buf_q[DATA_IN_W-1 -: DATA_OUT_W];
        ast_out.startofpacket = out_valid & sop_q & (cnt_q == '0);
        ast_out.endofpacket   = out_valid & eop_q & last_beat;
        ast_out.empty         = '0;
        if (out_valid && eop_q && last_beat) begin
            ast_out.empty = empty_q;
        end
        ast_out.channel       = chan_q;
    end

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        sop_d   = sop_q;
        eop_d   = eop_q;
        chan_d  = chan_q;
        empty_d = empty_q;
        total_d = total_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            StEmpty: begin
                if (in_xfer) begin
                    state_d = StSend;
                end
            end
            StSend: begin
                if (out_xfer) begin
                    if (last_beat) begin
                        if (!in_xfer) begin
                            state_d = StEmpty;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                        buf_d = buf_q << DATA_OUT_W;
                    end
                end
            end
            default: state_d = StEmpty;
        endcase

        // A load can only coincide with an idle buffer or a departing last beat.
        if (in_xfer) begin
            buf_d   = ast_in.data;
            sop_d   = ast_in.startofpacket;
            eop_d   = ast_in.endofpacket;
            chan_d  = ast_in.channel;
            empty_d = EMPTY_OUT_W'(in_pad);
            total_d = CNT_W'(in_beats);
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q  <= StEmpty;
            buf_q    <= '0;
            sop_q    <= 1'b0;
            eop_q    <= 1'b0;
            chan_q   <= '0;
            empty_q  <= '0;
            total_q  <= '0;
            cnt_q    <= '0;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            buf_q    <= buf_d;
            sop_q    <= sop_d;
            eop_q    <= eop_d;
            chan_q   <= chan_d;
            empty_q  <= empty_d;
            total_q  <= total_d;
            cnt_q    <= cnt_d;
            rdy_en_q <= 1'b1;
        end
    end

`ifndef SYNTHESIS
    a_hold_stall: assert property (
        @(posedge clk_i) disable iff (!arstn_i)
        (ast_out.valid && !ast_out.ready) |=> (ast_out.valid && $stable(ast_out.data)
            && $stable(ast_out.channel) && $stable(ast_out.endofpacket))
    );
`endif

endmodule

// File: tb/tb_ast_width_reducer.sv
// Self-checking bench for ast_width_reducer (256->64): table-driven packet runs, random traffic,
// and a mid-packet reset, all scored against a byte-level packet model.
module tb_ast_width_reducer;
    import ast_width_pkg::*;

    localparam int unsigned DIN  = 256;
    localparam int unsigned DOUT = 64;
    localparam int unsigned CHW  = 10;
    localparam int unsigned EIN  = 5;
    localparam int unsigned EOUT = 3;
    localparam int unsigned WIN  = 32;
    localparam int unsigned WOUT = 8;

    logic clk = 1'b0;
    logic arstn = 1'b0;
    always #5 clk = ~clk;

    ast_width_reducer_if #(.DATA_W(DIN), .EMPTY_W(EIN), .CHANNEL_W(CHW)) in_if ();
    ast_width_reducer_if #(.DATA_W(DOUT), .EMPTY_W(EOUT), .CHANNEL_W(CHW)) out_if ();

    ast_width_reducer #(
        .DATA_IN_W  (DIN),
        .DATA_OUT_W (DOUT),
        .CHANNEL_W  (CHW),
        .EMPTY_IN_W (EIN),
        .EMPTY_OUT_W(EOUT)
    ) dut (
        .clk_i  (clk),
        .arstn_i(arstn),
        .ast_in (in_if),
        .ast_out(out_if)
    );

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Packet-level reference model: bytes and channel of each packet in flight, plus the
    // number of narrow beats still owed for each accepted wide word.
    byte unsigned exp_bytes[$];
    int           exp_len[$];
    int           exp_ch[$];
    int           word_beats[$];
    byte unsigned got[$];
    int           got_beats = 0;
    bit           in_pkt = 1'b0;
    bit           stall_pend = 1'b0;
    logic [127:0] snap;
    int           last_beats = 0;
    int           last_empty = 0;
    int           pkts_done = 0;
    int           bubbles = 0;
    bit           armed;

    always @(posedge clk or negedge arstn) begin
        if (!arstn) armed <= 1'b0;
        else armed <= 1'b1;
    end

    always @(negedge clk) begin : mon
        logic         exp_rdy;
        logic [127:0] cur;
        int           nb;
        int           len;
        int           nbad;
        if (arstn && armed) begin
            exp_rdy = !out_if.valid ||
                      (out_if.ready && word_beats.size() > 0 && word_beats[0] == 1);
            check("ready_o", in_if.ready, exp_rdy);
            if (in_if.valid && !out_if.valid) bubbles++;

            cur = {out_if.valid, out_if.startofpacket, out_if.endofpacket, out_if.empty,
                   out_if.channel, out_if.data};
            if (stall_pend) check("stall_hold", cur, snap);
            stall_pend = out_if.valid && !out_if.ready;
            snap = cur;

            if (out_if.valid && out_if.ready) begin
                if (exp_len.size() == 0) begin
                    check("spurious_beat", out_if.valid, 1'b0);
                end else begin
                    check("sop_o", out_if.startofpacket, !in_pkt);
                    check("channel_o", out_if.channel, exp_ch[0]);
                    if (!in_pkt) begin
                        got.delete();
                        got_beats = 0;
                        in_pkt = 1'b1;
                    end
                    nb = out_if.endofpacket ? WOUT - out_if.empty : WOUT;
                    if (!out_if.endofpacket) check("empty_o_mid", out_if.empty, 0);
                    for (int i = 0; i < nb; i++) got.push_back(out_if.data[DOUT-1-8*i -: 8]);
                    got_beats++;
                    if (word_beats.size() > 0) begin
                        word_beats[0] = word_beats[0] - 1;
                        if (word_beats[0] == 0) void'(word_beats.pop_front());
                    end
                    if (out_if.endofpacket) begin
                        len = exp_len[0];
                        nbad = 0;
                        for (int i = 0; i < len; i++) begin
                            if (i >= got.size() || got[i] != exp_bytes[i]) nbad++;
                        end
                        check("pkt_len", got.size(), len);
                        check("pkt_bytes_bad", nbad, 0);
                        check("pkt_beats", got_beats, (len + WOUT - 1) / WOUT);
                        check("pkt_empty", out_if.empty, (WOUT - len % WOUT) % WOUT);
                        last_beats = got_beats;
                        last_empty = out_if.empty;
                        pkts_done++;
                        for (int i = 0; i < len; i++) void'(exp_bytes.pop_front());
                        void'(exp_len.pop_front());
                        void'(exp_ch.pop_front());
                        in_pkt = 1'b0;
                    end
                end
            end

            if (in_if.valid && in_if.ready) begin
                nb = in_if.endofpacket ? WIN - in_if.empty : WIN;
                word_beats.push_back((nb + WOUT - 1) / WOUT);
            end
        end
    end

    // Downstream ready: 0 = always on, 1 = two on / two off, 2 = random.
    int rmode = 0;
    int rcnt = 0;
    initial begin
        out_if.ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rcnt++;
            case (rmode)
                0: out_if.ready = 1'b1;
                1: out_if.ready = ((rcnt / 2) % 2) == 0;
                default: out_if.ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic drive_word(input logic [DIN-1:0] d, input bit sop, input bit eop,
                              input int emp, input int ch);
        bit ok;
        in_if.data = d;
        in_if.startofpacket = sop;
        in_if.endofpacket = eop;
        in_if.empty = EIN'(emp);
        in_if.channel = CHW'(ch);
        in_if.valid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            if (in_if.ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept_timeout", in_if.ready, 1'b1);
        @(posedge clk);
        #1;
        in_if.valid = 1'b0;
    endtask

    task automatic send_pkt(input int len, input int ch, input bit gaps);
        byte unsigned b[$];
        logic [DIN-1:0] d;
        int nw;
        int idx;
        int emp;
        for (int i = 0; i < len; i++) begin
            b.push_back(8'($urandom));
            exp_bytes.push_back(b[i]);
        end
        exp_len.push_back(len);
        exp_ch.push_back(ch);
        nw = (len + WIN - 1) / WIN;
        for (int w = 0; w < nw; w++) begin
            for (int k = 0; k < WIN; k++) begin
                idx = w * WIN + k;
                d[DIN-1-8*k -: 8] = (idx < len) ? b[idx] : 8'($urandom);
            end
            emp = (w == nw - 1) ? nw * WIN - len : $urandom_range(0, WIN - 1);
            drive_word(d, w == 0, w == nw - 1, emp, ch);
            if (gaps && $urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((exp_len.size() != 0 || out_if.valid) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 5000) check("drain_timeout", exp_len.size(), 0);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int len;
        int ch;
        int npkts;
        int rmode;
        int exp_beats;
        int exp_empty;
        int exp_bubbles;
    } vec_t;

    vec_t vec[7];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [DOUT-1:0] beat2;
        int b0;
        int p0;
        vec[0] = '{32, 1, 1, 0, 4, 0, -1};
        vec[1] = '{132, 2, 1, 0, 17, 4, -1};
        vec[2] = '{13, 3, 1, 0, 2, 3, -1};
        vec[3] = '{1, 4, 1, 0, 1, 7, -1};
        vec[4] = '{101, 9, 100, 0, 13, 3, 1};
        vec[5] = '{98, 11, 3, 1, 13, 6, -1};
        vec[6] = '{98, 15, 3, 1, 13, 6, -1};

        in_if.valid = 1'b0;
        in_if.data = '0;
        in_if.startofpacket = 1'b0;
        in_if.endofpacket = 1'b0;
        in_if.empty = '0;
        in_if.channel = '0;
        arstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", out_if.valid, 1'b0);
        check("rst_sop", out_if.startofpacket, 1'b0);
        check("rst_eop", out_if.endofpacket, 1'b0);
        check("rst_data", out_if.data, 0);
        check("rst_empty", out_if.empty, 0);
        check("rst_channel", out_if.channel, 0);
        check("rst_ready", in_if.ready, 1'b0);
        @(negedge clk);
        arstn = 1'b1;
        #1;
        check("ready_before_edge", in_if.ready, 1'b0);
        @(posedge clk);
        #1;
        check("ready_after_release", in_if.ready, 1'b1);

        for (int i = 0; i < 7; i++) begin
            rmode = vec[i].rmode;
            b0 = bubbles;
            p0 = pkts_done;
            for (int p = 0; p < vec[i].npkts; p++) send_pkt(vec[i].len, vec[i].ch, 1'b0);
            wait_drain();
            check($sformatf("vec%0d_pkts", i), pkts_done - p0, vec[i].npkts);
            check($sformatf("vec%0d_beats", i), last_beats, vec[i].exp_beats);
            check($sformatf("vec%0d_empty", i), last_empty, vec[i].exp_empty);
            if (vec[i].exp_bubbles >= 0) begin
                check($sformatf("vec%0d_bubbles", i), bubbles - b0, vec[i].exp_bubbles);
            end
        end

        rmode = 2;
        p0 = pkts_done;
        for (int p = 0; p < 40; p++) send_pkt($urandom_range(1, 200), $urandom_range(0, 1023), 1'b1);
        wait_drain();
        check("rand_pkts", pkts_done - p0, 40);

        // Reset while beat 2 of a single-word packet is on the output.
        rmode = 0;
        @(posedge clk);
        #1;
        send_pkt(32, 5, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        for (int k = 0; k < WOUT; k++) beat2[DOUT-1-8*k -: 8] = exp_bytes[2 * WOUT + k];
        check("beat2_data", out_if.data, beat2);
        #1;
        arstn = 1'b0;
        #1;
        check("mid_rst_valid", out_if.valid, 1'b0);
        check("mid_rst_ready", in_if.ready, 1'b0);
        exp_bytes.delete();
        exp_len.delete();
        exp_ch.delete();
        word_beats.delete();
        in_pkt = 1'b0;
        stall_pend = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        arstn = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_ready", in_if.ready, 1'b1);
        check("post_rst_no_beat", out_if.valid, 1'b0);
        p0 = pkts_done;
        send_pkt(32, 6, 1'b0);
        wait_drain();
        check("post_rst_pkts", pkts_done - p0, 1);
        check("post_rst_beats", last_beats, 4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
